// File: rtl/image_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : image_link_ctrl
// Description : Streams one image frame (IMG_W x IMG_H pixels, CHANNELS bytes
//               per pixel) byte by byte into a memory-mapped UART transmitter,
//               then reads RESULT_BYTES prediction bytes back from the UART
//               receiver. All bus traffic is Avalon-MM style master accesses
//               gated by avm_waitrequest; every byte access is preceded by a
//               status poll.
// Ports       : avm_clk / avm_rst      - clock, asynchronous active-high reset
//               avm_address/read/write/writedata, avm_readdata/waitrequest
//                                      - Avalon-MM master toward the UART
//               i_start / i_abort      - begin frame pulse / abandon frame
//               i_byte, i_byte_valid, o_byte_ready
//                                      - image byte source handshake
//               o_result, o_result_valid, o_result_idx
//                                      - received prediction bytes
//               o_busy, o_done, o_state - frame status
// Revision    : 1.0 - initial release
// ============================================================================
module image_link_ctrl #(
    parameter int IMG_W        = 640,
    parameter int IMG_H        = 480,
    parameter int CHANNELS     = 3,
    parameter int RESULT_BYTES = 124,
    localparam int c_idx_w     = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1
) (
    input  logic               avm_clk,
    input  logic               avm_rst,
    output logic [4:0]         avm_address,
    output logic               avm_read,
    input  logic [31:0]        avm_readdata,
    output logic               avm_write,
    output logic [31:0]        avm_writedata,
    input  logic               avm_waitrequest,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    output logic [7:0]         o_result,
    output logic               o_result_valid,
    output logic [c_idx_w-1:0] o_result_idx,
    output logic               o_busy,
    output logic               o_done,
    output logic [2:0]         o_state
);

    localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_h_w  = (IMG_W > 1)    ? $clog2(IMG_W)    : 1;
    localparam int c_v_w  = (IMG_H > 1)    ? $clog2(IMG_H)    : 1;

    localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(CHANNELS - 1);
    localparam logic [c_h_w-1:0]   c_h_last   = c_h_w'(IMG_W - 1);
    localparam logic [c_v_w-1:0]   c_v_last   = c_v_w'(IMG_H - 1);
    localparam logic [c_idx_w-1:0] c_res_last = c_idx_w'(RESULT_BYTES - 1);

    localparam logic [4:0] c_addr_rx   = 5'd0;
    localparam logic [4:0] c_addr_tx   = 5'd4;
    localparam logic [4:0] c_addr_stat = 5'd8;

    localparam int c_bit_tx_rdy = 6;
    localparam int c_bit_rx_rdy = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TX_POLL  = 3'd1,
        TX_WRITE = 3'd2,
        RX_POLL  = 3'd3,
        RX_READ  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t             r_state;
    logic [c_ch_w-1:0]  r_ch;
    logic [c_h_w-1:0]   r_h;
    logic [c_v_w-1:0]   r_v;
    logic [c_idx_w-1:0] r_res;

    logic w_last_px;
    logic w_abort_take;
    logic w_unused;

    assign w_last_px = (r_ch == c_ch_last) && (r_h == c_h_last) && (r_v == c_v_last);

    // An abort is honoured only where no access is outstanding (IDLE/DONE) or
    // on the cycle that completes the outstanding access, so the bus never
    // sees a strobe withdrawn while stalled.
    assign w_abort_take = i_abort &&
                          ((r_state == IDLE) || (r_state == DONE) || !avm_waitrequest);

    assign o_busy  = (r_state != IDLE);
    assign o_state = r_state;

    // Only the low byte of the UART registers carries information.
    assign w_unused = ^avm_readdata[31:8];

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_state        <= IDLE;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= c_addr_stat;
            avm_writedata  <= 32'd0;
            o_byte_ready   <= 1'b0;
            o_result_valid <= 1'b0;
            o_done         <= 1'b0;
            o_result       <= 8'd0;
            o_result_idx   <= '0;
            r_ch           <= '0;
            r_h            <= '0;
            r_v            <= '0;
            r_res          <= '0;
        end else begin
            // Single-cycle strobes default low.
            o_byte_ready   <= 1'b0;
            o_result_valid <= 1'b0;
            o_done         <= 1'b0;

            if (w_abort_take) begin
                r_state     <= IDLE;
                avm_read    <= 1'b0;
                avm_write   <= 1'b0;
                avm_address <= c_addr_stat;
                r_ch        <= '0;
                r_h         <= '0;
                r_v         <= '0;
                r_res       <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (i_start) begin
                            r_ch        <= '0;
                            r_h         <= '0;
                            r_v         <= '0;
                            r_res       <= '0;
                            avm_address <= c_addr_stat;
                            avm_read    <= 1'b1;
                            r_state     <= TX_POLL;
                        end
                    end

                    TX_POLL: begin
                        // Without a ready transmitter and a byte on hand, the
                        // status read stays asserted: back-to-back polls.
                        if (!avm_waitrequest && avm_readdata[c_bit_tx_rdy] && i_byte_valid) begin
                            o_byte_ready  <= 1'b1;
                            avm_writedata <= {24'd0, i_byte};
                            avm_read      <= 1'b0;
                            avm_write     <= 1'b1;
                            avm_address   <= c_addr_tx;
                            r_state       <= TX_WRITE;
                        end
                    end

                    TX_WRITE: begin
                        if (!avm_waitrequest) begin
                            avm_write   <= 1'b0;
                            avm_read    <= 1'b1;
                            avm_address <= c_addr_stat;
                            // channel is the innermost counter, then h, then v
                            if (r_ch == c_ch_last) begin
                                r_ch <= '0;
                                if (r_h == c_h_last) begin
                                    r_h <= '0;
                                    if (r_v == c_v_last) begin
                                        r_v <= '0;
                                    end else begin
                                        r_v <= r_v + 1'b1;
                                    end
                                end else begin
                                    r_h <= r_h + 1'b1;
                                end
                            end else begin
                                r_ch <= r_ch + 1'b1;
                            end
                            r_state <= w_last_px ? RX_POLL : TX_POLL;
                        end
                    end

                    RX_POLL: begin
                        if (!avm_waitrequest && avm_readdata[c_bit_rx_rdy]) begin
                            avm_address <= c_addr_rx;
                            r_state     <= RX_READ;
                        end
                    end

                    RX_READ: begin
                        if (!avm_waitrequest) begin
                            o_result       <= avm_readdata[7:0];
                            o_result_idx   <= r_res;
                            o_result_valid <= 1'b1;
                            avm_address    <= c_addr_stat;
                            if (r_res == c_res_last) begin
                                r_res    <= '0;
                                avm_read <= 1'b0;
                                o_done   <= 1'b1;
                                r_state  <= DONE;
                            end else begin
                                r_res   <= r_res + 1'b1;
                                r_state <= RX_POLL;
                            end
                        end
                    end

                    DONE: begin
                        r_state <= IDLE;
                    end

                    default: begin
                        r_state   <= IDLE;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_link_ctrl
// Description : Directed self-checking bench for image_link_ctrl with a 2x2
//               single-channel frame and 3 result bytes. A negedge-driven UART
//               slave model supplies status/RX data, optional waitrequest
//               stalls, and logs every completed access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_link_ctrl;

    localparam int IMG_W        = 2;
    localparam int IMG_H        = 2;
    localparam int CHANNELS     = 1;
    localparam int RESULT_BYTES = 3;

    localparam logic [52:0] RST_OUTS = {1'b0, 1'b0, 5'd8, 32'd0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};

    logic        avm_clk = 1'b0;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic [7:0]  o_result;
    logic        o_result_valid;
    logic [1:0]  o_result_idx;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_state;

    image_link_ctrl #(
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .CHANNELS     (CHANNELS),
        .RESULT_BYTES (RESULT_BYTES)
    ) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_byte          (i_byte),
        .i_byte_valid    (i_byte_valid),
        .o_byte_ready    (o_byte_ready),
        .o_result        (o_result),
        .o_result_valid  (o_result_valid),
        .o_result_idx    (o_result_idx),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_state         (o_state)
    );

    always #5 avm_clk = ~avm_clk;

    logic [52:0] outs_vec;
    assign outs_vec = {avm_read, avm_write, avm_address, avm_writedata,
                       o_byte_ready, o_result_valid, o_done, o_busy,
                       o_result, o_result_idx};

    int checks   = 0;
    int failures = 0;

    // stimulus knobs (written only by the main sequence)
    int   stall_n    = 0;
    int   hold_until = 0;
    logic rx_block   = 1'b0;

    // slave model / logs (written only by the monitor)
    int          status_reads = 0;
    int          tx_n = 0, rdy_n = 0, res_n = 0, done_n = 0;
    int          src_idx = 0, rx_idx = 0;
    int          wcnt = 0, stab_err = 0, hi_err = 0;
    logic        in_acc = 1'b0;
    logic [38:0] snap;
    logic [7:0]  tx_log   [64];
    int          wr_polls [64];
    int          rdy_polls[64];
    logic [7:0]  res_log  [64];
    logic [1:0]  idx_log  [64];

    // Byte source: consecutive distinct values 0x11, 0x22, 0x33, 0x44, ...
    function automatic logic [7:0] src_fn(input int i);
        return 8'((i + 1) * 17);
    endfunction

    always @(negedge avm_clk) begin
        if (o_byte_ready) begin
            rdy_polls[rdy_n] = status_reads;
            rdy_n++;
            src_idx++;
        end
        i_byte = src_fn(src_idx);
        if (o_result_valid) begin
            res_log[res_n] = o_result;
            idx_log[res_n] = o_result_idx;
            res_n++;
        end
        if (o_done) done_n++;

        avm_readdata = 32'd0;
        if (avm_address == 5'd8)
            avm_readdata = {24'd0, !rx_block, (status_reads >= hold_until), 6'd0};
        else if (avm_address == 5'd0)
            avm_readdata = {24'd0, 8'hA0 + 8'(rx_idx % 3)};

        if (avm_read || avm_write) begin
            if (in_acc) begin
                if ({avm_address, avm_read, avm_write, avm_writedata} !== snap) stab_err++;
            end else begin
                in_acc = 1'b1;
                wcnt   = 0;
                snap   = {avm_address, avm_read, avm_write, avm_writedata};
            end
            if (wcnt < stall_n) begin
                avm_waitrequest = 1'b1;
                wcnt++;
            end else begin
                avm_waitrequest = 1'b0;
                in_acc = 1'b0;
                if (avm_write) begin
                    tx_log[tx_n]   = avm_writedata[7:0];
                    wr_polls[tx_n] = status_reads;
                    if (avm_writedata[31:8] != 24'd0) hi_err++;
                    tx_n++;
                end else if (avm_address == 5'd8) begin
                    status_reads++;
                end else begin
                    rx_idx++;
                end
            end
        end else begin
            avm_waitrequest = 1'b0;
            in_acc = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge avm_clk);
        i_start = 1'b1;
        @(negedge avm_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 3000 && done_n == d0; k++) @(negedge avm_clk);
        repeat (3) @(negedge avm_clk);
    endtask

    task automatic check_frame(input string tag, input int tb0, input int sb0,
                               input int rb0, input int db0, input int yb0);
        chk({tag, " tx count"}, 64'(tx_n - tb0), 64'd4);
        chk({tag, " byte_ready count"}, 64'(rdy_n - yb0), 64'd4);
        for (int k = 0; k < 4; k++)
            chk({tag, " tx byte"}, 64'(tx_log[tb0 + k]), 64'(src_fn(sb0 + k)));
        chk({tag, " result count"}, 64'(res_n - rb0), 64'd3);
        chk({tag, " results"}, 64'({res_log[rb0], res_log[rb0 + 1], res_log[rb0 + 2]}),
            64'h00A0A1A2);
        chk({tag, " result idx"}, 64'({idx_log[rb0], idx_log[rb0 + 1], idx_log[rb0 + 2]}),
            64'b000110);
        chk({tag, " done pulses"}, 64'(done_n - db0), 64'd1);
        chk({tag, " idle after"}, 64'({o_state, o_busy}), 64'd0);
    endtask

    initial begin
        int tb0, sb0, rb0, db0, yb0, pb0, se0, pc;

        avm_rst      = 1'b1;
        i_start      = 1'b0;
        i_abort      = 1'b0;
        i_byte_valid = 1'b0;
        repeat (3) @(negedge avm_clk);
        chk("reset outputs", 64'(outs_vec), 64'(RST_OUTS));
        chk("reset state", 64'(o_state), 64'd0);
        avm_rst = 1'b0;

        // abort beats start in IDLE
        @(negedge avm_clk);
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge avm_clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("start+abort stays idle", 64'({o_state, o_busy, avm_read}), 64'd0);

        // single clean frame
        i_byte_valid = 1'b1;
        hold_until = status_reads;
        tb0 = tx_n; sb0 = src_idx; rb0 = res_n; db0 = done_n; yb0 = rdy_n;
        start_frame();
        wait_done(db0);
        check_frame("basic", tb0, sb0, rb0, db0, yb0);

        // transmitter not ready for 10 polls
        pb0 = status_reads;
        hold_until = status_reads + 10;
        tb0 = tx_n; sb0 = src_idx; rb0 = res_n; db0 = done_n; yb0 = rdy_n;
        start_frame();
        wait_done(db0);
        chk("txbusy first write after poll", 64'(wr_polls[tb0] - pb0), 64'd11);
        chk("txbusy first byte_ready after poll", 64'(rdy_polls[yb0] - pb0), 64'd11);
        check_frame("txbusy", tb0, sb0, rb0, db0, yb0);
        hold_until = 0;

        // 3-cycle waitrequest on every access
        stall_n = 3;
        se0 = stab_err;
        tb0 = tx_n; sb0 = src_idx; rb0 = res_n; db0 = done_n; yb0 = rdy_n;
        start_frame();
        wait_done(db0);
        chk("stall outputs stable", 64'(stab_err - se0), 64'd0);
        check_frame("stall", tb0, sb0, rb0, db0, yb0);
        stall_n = 0;

        // byte source gap mid-frame
        tb0 = tx_n; sb0 = src_idx; rb0 = res_n; db0 = done_n; yb0 = rdy_n;
        start_frame();
        for (int k = 0; k < 500 && (src_idx - sb0) < 2; k++) @(negedge avm_clk);
        i_byte_valid = 1'b0;
        @(negedge avm_clk);
        pc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge avm_clk);
            if (avm_read && !avm_write && avm_address == 5'd8 && o_state == 3'd1) pc++;
        end
        chk("gap continuous polling", 64'(pc), 64'd5);
        chk("gap no consumption", 64'(rdy_n - yb0), 64'd2);
        i_byte_valid = 1'b1;
        wait_done(db0);
        check_frame("gap", tb0, sb0, rb0, db0, yb0);

        // abort after the second TX write
        tb0 = tx_n; db0 = done_n; yb0 = rdy_n;
        start_frame();
        for (int k = 0; k < 500 && (tx_n - tb0) < 2; k++) begin
            @(posedge avm_clk);
            #1;
        end
        i_abort = 1'b1;
        @(posedge avm_clk);
        #1;
        i_abort = 1'b0;
        repeat (4) @(negedge avm_clk);
        chk("abort idle", 64'({o_state, o_busy}), 64'd0);
        chk("abort no done", 64'(done_n - db0), 64'd0);
        chk("abort tx writes", 64'(tx_n - tb0), 64'd2);
        chk("abort no further consume", 64'(rdy_n - yb0), 64'd2);
        tb0 = tx_n; sb0 = src_idx; rb0 = res_n; db0 = done_n; yb0 = rdy_n;
        start_frame();
        wait_done(db0);
        check_frame("after abort", tb0, sb0, rb0, db0, yb0);

        // reset while polling for RX data
        rx_block = 1'b1;
        db0 = done_n;
        start_frame();
        for (int k = 0; k < 500 && o_state != 3'd3; k++) @(negedge avm_clk);
        chk("reached rx_poll", 64'(o_state), 64'd3);
        repeat (2) @(negedge avm_clk);
        #2;
        avm_rst = 1'b1;
        #1;
        chk("async reset outputs", 64'(outs_vec), 64'(RST_OUTS));
        chk("async reset state", 64'(o_state), 64'd0);
        @(negedge avm_clk);
        avm_rst  = 1'b0;
        rx_block = 1'b0;
        repeat (5) @(negedge avm_clk);
        chk("post reset waits", 64'({o_state, avm_read, avm_write}), 64'd0);
        chk("reset no done", 64'(done_n - db0), 64'd0);

        // normal frame after reset
        tb0 = tx_n; sb0 = src_idx; rb0 = res_n; db0 = done_n; yb0 = rdy_n;
        start_frame();
        wait_done(db0);
        check_frame("after reset", tb0, sb0, rb0, db0, yb0);

        chk("writedata upper bits zero", 64'(hi_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_link_ctrl.md
IMAGE_LINK_CTRL -- requirements
Module: image_link_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- CHANNELS, 3, bytes per pixel.
- RESULT_BYTES, 124, prediction bytes read back per frame.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- avm_clk, in, 1, clock.
- avm_rst, in, 1, asynchronous active-high reset.
- avm_address, out, 5, UART register byte address.
- avm_read, out, 1, read strobe.
- avm_readdata, in, 32, read data.
- avm_write, out, 1, write strobe.
- avm_writedata, out, 32, write data; bits 31:8 always 0.
- avm_waitrequest, in, 1, slave stall.
- i_start, in, 1, begin frame (pulse).
- i_abort, in, 1, abandon frame.
- i_byte, in, 8, image byte.
- i_byte_valid, in, 1, i_byte present.
- o_byte_ready, out, 1, i_byte consumed this cycle.
- o_result, out, 8, received prediction byte.
- o_result_valid, out, 1, o_result strobe.
- o_result_idx, out, clog2(RESULT_BYTES), index of o_result.
- o_busy, out, 1, frame in progress.
- o_done, out, 1, frame complete pulse.
- o_state, out, 3, current FSM state.

Function
REQ-003 Register map SHALL be: RX data at 0, TX data at 4, status at 8; status bit 6 = TX ready, bit 7 = RX ready.
REQ-004 FSM states and encodings SHALL be IDLE=0, TX_POLL=1, TX_WRITE=2, RX_POLL=3, RX_READ=4, DONE=5.
REQ-005 An access SHALL hold address, strobe and writedata registered and stable until the cycle in which avm_waitrequest is low; that cycle completes the access.
REQ-006 Read data SHALL be sampled only in the completing cycle of a read.
REQ-007 In IDLE, avm_read and avm_write SHALL be 0.
REQ-008 i_start in IDLE SHALL clear all counters and enter TX_POLL at the next edge.
REQ-009 i_start outside IDLE SHALL be ignored.
REQ-010 TX_POLL SHALL read status.
REQ-011 On TX_POLL completion with bit 6 = 1 and i_byte_valid = 1, o_byte_ready SHALL pulse for one cycle, i_byte SHALL be latched into writedata, and the FSM SHALL enter TX_WRITE.
REQ-012 On TX_POLL completion otherwise, the FSM SHALL re-issue the status read with no idle cycle.
REQ-013 TX_WRITE SHALL write TX; on completion, channel/h/v counters SHALL advance in that nesting order (channel wraps at CHANNELS-1, h at IMG_W-1, v at IMG_H-1).
REQ-014 The write completing with channel=CHANNELS-1, h=IMG_W-1, v=IMG_H-1 SHALL go to RX_POLL; all other TX_WRITE completions SHALL go to TX_POLL.
REQ-015 RX_POLL SHALL read status; bit 7 = 1 on completion SHALL go to RX_READ, else re-poll.
REQ-016 RX_READ SHALL read RX data.
REQ-017 On RX_READ completion, o_result SHALL be readdata[7:0], o_result_idx SHALL be the current result counter, and o_result_valid SHALL be 1 for exactly the next cycle.
REQ-018 After an RX_READ completion the result counter SHALL increment; the read at index RESULT_BYTES-1 SHALL go to DONE, all others to RX_POLL.
REQ-019 DONE SHALL last one cycle with o_done=1, then enter IDLE.
REQ-020 o_busy SHALL be 1 in every state except IDLE.
REQ-021 i_abort SHALL take effect only at an access-completing cycle (or immediately if no access is pending).
REQ-022 On abort the FSM SHALL enter IDLE, clear counters, assert no o_done, and issue no further byte consumption.
REQ-023 If i_abort and i_start are high together in IDLE, i_abort SHALL win.
REQ-024 Counter widths SHALL be clog2 of their limits (minimum 1 bit); no counter SHALL exceed its terminal value.

Reset
REQ-025 Asserting avm_rst SHALL immediately force: state IDLE; avm_read=0, avm_write=0, avm_address=8, avm_writedata=0; o_byte_ready=0, o_result_valid=0, o_done=0, o_busy=0; o_result=0, o_result_idx=0; all counters 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no o_done.
REQ-027 After reset is released, the block SHALL wait for a new i_start.

Verification (IMG_W=2, IMG_H=2, CHANNELS=1, RESULT_BYTES=3)
REQ-028 Single frame, status=0xC0, waitrequest=0, bytes 0x11,0x22,0x33,0x44, RX returns 0xA0,0xA1,0xA2 -> 4 TX writes carrying exactly those bytes, 3 results with idx 0,1,2, one o_done pulse, back to IDLE.
REQ-029 Status bit 6 held 0 for 10 polls, then 1 -> no TX write and no o_byte_ready during the 10 polls; the write follows the first ready poll.
REQ-030 waitrequest held 3 cycles on every access -> strobes and address stable throughout each stall; data identical to the REQ-028 case.
REQ-031 i_byte_valid low for 5 cycles mid-frame -> continuous status polling, no byte lost or duplicated.
REQ-032 i_abort pulsed after 2nd TX write -> IDLE, o_busy=0, no o_done; a subsequent i_start sends 4 fresh bytes.
REQ-033 avm_rst asserted in RX_POLL -> all outputs at REQ-025 values within the same cycle.
